mux_forzado_multicanal: RTL and testbench

Parametrised N-channel output multiplexer with round-robin burst arbitration and forced-symbol insertion. It is the next generation of the forced-control mux: it generalises width and channel count, and adds per-channel pop handshakes, burst locking, software-selectable modes and an optional periodic skip symbol. It sits between the per-lane FIFOs and the serialiser, and it drives a registered byte stream plus qualifiers.

---
 rtl/mux_forzado_multicanal_pkg.sv | 22 ++
 rtl/mux_forzado_multicanal_arbitro_rr.sv | 33 +++
 rtl/mux_forzado_multicanal.sv | 172 +++++++++++++++++
 tb/tb_mux_forzado_multicanal.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_forzado_multicanal_pkg.sv
// Shared definitions for the multichannel forced-symbol mux: operating modes,
// arbitration states and the index-width helper.
package mux_forzado_multicanal_pkg;

  typedef enum logic [1:0] {
    MODO_RR     = 2'b00,
    MODO_FIJO   = 2'b01,
    MODO_FORZAR = 2'b10,
    MODO_PAUSA  = 2'b11
  } modo_e;

  typedef enum logic {
    ESPERA = 1'b0,
    ENVIO  = 1'b1
  } estado_e;

  // Never returns 0 so a 1-channel or 1-value index still gets one bit.
  function automatic int clog2_f(input int valor);
    return (valor <= 2) ? 1 : $clog2(valor);
  endfunction

endpackage

// File: rtl/mux_forzado_multicanal_arbitro_rr.sv
// Combinational round-robin arbiter: first requesting channel at or after ptr,
// wrapping from N_CANALES-1 back to 0.
module mux_forzado_multicanal_arbitro_rr
  import mux_forzado_multicanal_pkg::*;
#(
  parameter  int N_CANALES = 4,
  localparam int IW        = clog2_f(N_CANALES)
) (
  input  logic [N_CANALES-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [N_CANALES-1:0] gnt,
  output logic [IW-1:0]        idx,
  output logic                 hay_req
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    hay_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      cand = IW'((int'(ptr) + i) % N_CANALES);
      if (!hay_req && req[cand]) begin
        hay_req   = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mux_forzado_multicanal.sv
// N-channel output mux with round-robin burst arbitration and forced-symbol fill.
// Optional periodic skip symbol enabled by defining MUXF_SKIP_EN.
module mux_forzado_multicanal
  import mux_forzado_multicanal_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int N_CANALES   = 4,
  parameter  int BURST_LEN   = 4,
  parameter  int SKIP_PERIOD = 16,
  localparam int IW          = clog2_f(N_CANALES)
) (
  input  logic                          CLK,
  input  logic                          RESET_L,
  input  logic [N_CANALES*DATA_W-1:0]   DATA_IN,
  input  logic [N_CANALES-1:0]          VALID_IN,
  output logic [N_CANALES-1:0]          POP_OUT,
  input  logic [1:0]                    MODE,
  input  logic [IW-1:0]                 SEL,
  input  logic [DATA_W-1:0]             FORCE_DATA,
  output logic [DATA_W-1:0]             OUT,
  output logic                          VALID_OUT,
  output logic                          FORZADO_OUT
);

  localparam int NP = 1 << IW;
  localparam int CW = clog2_f(BURST_LEN + 1);

  modo_e               modo;
  estado_e             estado_q, estado_d;
  logic [IW-1:0]       canal_q, canal_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cuenta_q, cuenta_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                forzado_q, forzado_d;

  logic [N_CANALES-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_hay;
  logic [N_CANALES-1:0] pop_vec;
  logic [IW-1:0]        pop_idx;
  logic                 hay_pop;
  logic                 skip_now;
  logic [NP-1:0]        valid_ext;
  logic [DATA_W-1:0]    datos [NP];

  assign modo      = modo_e'(MODE);
  assign valid_ext = NP'(VALID_IN);

  // Pad the word array to a power of two so any SEL/index value is in range.
  for (genvar k = 0; k < NP; k++) begin : g_datos
    if (k < N_CANALES) begin : g_real
      assign datos[k] = DATA_IN[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign datos[k] = '0;
    end
  end

  mux_forzado_multicanal_arbitro_rr #(
    .N_CANALES (N_CANALES)
  ) u_arbitro (
    .req     (VALID_IN),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .hay_req (arb_hay)
  );

`ifdef MUXF_SKIP_EN
  localparam int SW = clog2_f(SKIP_PERIOD + 1);
  logic [SW-1:0] skip_q, skip_d;

  assign skip_now = (skip_q == SW'(SKIP_PERIOD));
  // Any cycle without a pop (skip, idle fill, force, pause) restarts the run.
  assign skip_d   = hay_pop ? skip_q + SW'(1) : '0;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) skip_q <= '0;
    else          skip_q <= skip_d;
  end
`else
  assign skip_now = (SKIP_PERIOD < 0);
`endif

  always_comb begin
    estado_d = estado_q;
    canal_d  = canal_q;
    ptr_d    = ptr_q;
    cuenta_d = cuenta_q;
    pop_vec  = '0;
    pop_idx  = canal_q;
    hay_pop  = 1'b0;
    unique case (modo)
      MODO_RR: begin
        if (skip_now) begin
          // Lock kept, burst count frozen for the skip slot.
        end else if (estado_q == ENVIO && VALID_IN[canal_q] && cuenta_q < CW'(BURST_LEN)) begin
          hay_pop          = 1'b1;
          pop_idx          = canal_q;
          pop_vec[canal_q] = 1'b1;
          cuenta_d         = cuenta_q + CW'(1);
        end else if (arb_hay) begin
          hay_pop  = 1'b1;
          pop_idx  = arb_idx;
          pop_vec  = arb_gnt;
          canal_d  = arb_idx;
          cuenta_d = CW'(1);
          ptr_d    = (arb_idx == IW'(N_CANALES - 1)) ? '0 : arb_idx + IW'(1);
          estado_d = ENVIO;
        end else begin
          estado_d = ESPERA;
          cuenta_d = '0;
        end
      end
      MODO_FIJO: begin
        estado_d = ESPERA;
        cuenta_d = '0;
        if (!skip_now && valid_ext[SEL]) begin
          hay_pop      = 1'b1;
          pop_idx      = SEL;
          pop_vec[SEL] = 1'b1;
        end
      end
      default: begin
        estado_d = ESPERA;
        cuenta_d = '0;
      end
    endcase
  end

  always_comb begin
    if (hay_pop) begin
      out_d     = datos[pop_idx];
      valid_d   = 1'b1;
      forzado_d = 1'b0;
    end else if (modo == MODO_PAUSA) begin
      out_d     = out_q;
      valid_d   = 1'b0;
      forzado_d = 1'b0;
    end else begin
      out_d     = FORCE_DATA;
      valid_d   = 1'b0;
      forzado_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      estado_q  <= ESPERA;
      canal_q   <= '0;
      ptr_q     <= '0;
      cuenta_q  <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      forzado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      canal_q   <= canal_d;
      ptr_q     <= ptr_d;
      cuenta_q  <= cuenta_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      forzado_q <= forzado_d;
    end
  end

  assign POP_OUT     = RESET_L ? pop_vec : '0;
  assign OUT         = out_q;
  assign VALID_OUT   = valid_q;
  assign FORZADO_OUT = forzado_q;

endmodule

// File: tb/tb_mux_forzado_multicanal.sv
// Table-driven bench for mux_forzado_multicanal with a one-deep output scoreboard.
module tb_mux_forzado_multicanal;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int SP = 16;

  logic           CLK = 1'b0;
  logic           RESET_L = 1'b0;
  logic [N*W-1:0] DATA_IN = '0;
  logic [N-1:0]   VALID_IN = '0;
  logic [N-1:0]   POP_OUT;
  logic [1:0]     MODE = 2'b00;
  logic [1:0]     SEL = 2'd0;
  logic [W-1:0]   FORCE_DATA = 8'hFF;
  logic [W-1:0]   OUT;
  logic           VALID_OUT;
  logic           FORZADO_OUT;

  mux_forzado_multicanal #(
    .DATA_W      (W),
    .N_CANALES   (N),
    .BURST_LEN   (BL),
    .SKIP_PERIOD (SP)
  ) dut (
    .CLK         (CLK),
    .RESET_L     (RESET_L),
    .DATA_IN     (DATA_IN),
    .VALID_IN    (VALID_IN),
    .POP_OUT     (POP_OUT),
    .MODE        (MODE),
    .SEL         (SEL),
    .FORCE_DATA  (FORCE_DATA),
    .OUT         (OUT),
    .VALID_OUT   (VALID_OUT),
    .FORZADO_OUT (FORZADO_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic [7:0] fdat;
    logic [3:0] pop;
    bit         rst;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       v;
    logic       f;
  } exp_t;

  vec_t       tabla[$];
  exp_t       sb[$];
  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] s = 4'd0;
  logic [7:0] last_out = 8'h00;

  function automatic logic [7:0] word(input int k, input logic [3:0] st);
    return 8'((k + 1) * 16) | {4'h0, st};
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic vec_t mk(input logic [1:0] mode, input logic [1:0] sel,
                              input logic [3:0] valid, input logic [7:0] fdat,
                              input logic [3:0] pop, input bit rst);
    vec_t v;
    v.mode = mode; v.sel = sel; v.valid = valid; v.fdat = fdat; v.pop = pop; v.rst = rst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    MODE     = 2'b00;
    VALID_IN = '1;
    #2;
    RESET_L  = 1'b0;
    #1;
    chk("rst_out", 32'(OUT), 32'h0);
    chk("rst_valid", 32'(VALID_OUT), 32'h0);
    chk("rst_forzado", 32'(FORZADO_OUT), 32'h0);
    chk("rst_pop", 32'(POP_OUT), 32'h0);
    sb.delete();
    last_out = 8'h00;
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge CLK);
    RESET_L    = 1'b1;
    s          = s + 4'd1;
    DATA_IN    = {word(3, s), word(2, s), word(1, s), word(0, s)};
    MODE       = v.mode;
    SEL        = v.sel;
    VALID_IN   = v.valid;
    FORCE_DATA = v.fdat;
    #1;
    chk("pop", 32'(POP_OUT), 32'(v.pop));
    if (v.pop != 4'b0000) begin
      e.out = word(idx_of(v.pop), s); e.v = 1'b1; e.f = 1'b0;
    end else if (v.mode == 2'b11) begin
      e.out = last_out; e.v = 1'b0; e.f = 1'b0;
    end else begin
      e.out = v.fdat; e.v = 1'b0; e.f = 1'b1;
    end
    last_out = e.out;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() != 1) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_depth: got %0d expected 1", sb.size());
    end else begin
      e = sb.pop_front();
      chk("out", 32'(OUT), 32'(e.out));
      chk("valid_out", 32'(VALID_OUT), 32'(e.v));
      chk("forzado_out", 32'(FORZADO_OUT), 32'(e.f));
    end
  endtask

  initial begin
    MODE     = 2'b00;
    VALID_IN = '1;
    #2;
    chk("init_out", 32'(OUT), 32'h0);
    chk("init_valid", 32'(VALID_OUT), 32'h0);
    chk("init_forzado", 32'(FORZADO_OUT), 32'h0);
    chk("init_pop", 32'(POP_OUT), 32'h0);

`ifdef MUXF_SKIP_EN
    for (int i = 0; i < 34; i++)
      tabla.push_back(mk(2'b00, 2'd0, 4'b1111, 8'hFF,
                         ((i % 17) == 16) ? 4'b0000 : 4'(1 << ((i % 17) / 4)), i == 0));
`else
    // Burst rotation from reset: four words per channel, pointer order.
    for (int i = 0; i < 20; i++)
      tabla.push_back(mk(2'b00, 2'd0, 4'b1111, 8'hFF, 4'(1 << ((i / 4) % 4)), 1'b0));
    // Early burst end on channel 1, channel 3 takes over without a bubble.
    tabla.push_back(mk(2'b00, 2'd0, 4'b1010, 8'hFF, 4'b0010, 1'b1));
    tabla.push_back(mk(2'b00, 2'd0, 4'b1010, 8'hFF, 4'b0010, 1'b0));
    for (int i = 0; i < 4; i++)
      tabla.push_back(mk(2'b00, 2'd0, 4'b1000, 8'hFF, 4'b1000, 1'b0));
    tabla.push_back(mk(2'b00, 2'd0, 4'b1010, 8'hFF, 4'b0010, 1'b0));
    tabla.push_back(mk(2'b00, 2'd0, 4'b1010, 8'hFF, 4'b0010, 1'b0));
    // Fixed channel.
    for (int i = 0; i < 3; i++)
      tabla.push_back(mk(2'b01, 2'd2, 4'b1111, 8'hFF, 4'b0100, 1'b0));
    tabla.push_back(mk(2'b01, 2'd2, 4'b1011, 8'hFF, 4'b0000, 1'b0));
    tabla.push_back(mk(2'b01, 2'd0, 4'b1111, 8'hFF, 4'b0001, 1'b0));
    // Force mode.
    tabla.push_back(mk(2'b10, 2'd0, 4'b1111, 8'hFF, 4'b0000, 1'b0));
    tabla.push_back(mk(2'b10, 2'd0, 4'b1111, 8'hFF, 4'b0000, 1'b0));
    tabla.push_back(mk(2'b10, 2'd0, 4'b1111, 8'hA5, 4'b0000, 1'b0));
    // Back to round-robin: pointer preserved at 2; then idle fill.
    tabla.push_back(mk(2'b00, 2'd0, 4'b1111, 8'hFF, 4'b0100, 1'b0));
    tabla.push_back(mk(2'b00, 2'd0, 4'b0000, 8'h3C, 4'b0000, 1'b0));
    tabla.push_back(mk(2'b00, 2'd0, 4'b0000, 8'hFF, 4'b0000, 1'b0));
    // Data word then pause: OUT holds it.
    tabla.push_back(mk(2'b00, 2'd0, 4'b0001, 8'hFF, 4'b0001, 1'b0));
    for (int i = 0; i < 3; i++)
      tabla.push_back(mk(2'b11, 2'd0, 4'b1111, 8'hFF, 4'b0000, 1'b0));
    // Single valid channel: burst by count re-arbitrates back to itself.
    for (int i = 0; i < 6; i++)
      tabla.push_back(mk(2'b00, 2'd0, 4'b0100, 8'hFF, 4'b0100, 1'b0));
`endif

    foreach (tabla[i]) begin
      if (tabla[i].rst) reset_pulse();
      step(tabla[i]);
    end

    // Reset in the middle of channel 1's burst: channel 0 goes first again.
    reset_pulse();
    for (int i = 0; i < 6; i++)
      step(mk(2'b00, 2'd0, 4'b1111, 8'hFF, (i < 4) ? 4'b0001 : 4'b0010, 1'b0));
    reset_pulse();
    step(mk(2'b00, 2'd0, 4'b1111, 8'hFF, 4'b0001, 1'b0));
    step(mk(2'b00, 2'd0, 4'b1111, 8'hFF, 4'b0001, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
